hazard_ctrl: RTL and testbench

- Stall/flush controller for the 5-stage RV32 pipeline.
- Handles the hazards that forwarding cannot resolve: load-use, taken-branch redirect, and I-/D-cache miss stalls.
- Drives the write enables and flush strobes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps one-deep redirect state so a branch taken during an I-cache miss discards the wrong-path fetch when it returns.

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline: load-use, taken-branch redirect and cache-miss stalls.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic             ex_branch_taken,
  input  logic             ic_stall,
  input  logic             dc_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             redir_pend,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] redir_cnt,
  output logic [CNT_W-1:0] dstall_cnt
);

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_WAIT = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   lu;
  logic   lu_resp;
  logic   redir_acc;

  assign lu = ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_next = state_reg;
    lu_resp    = 1'b0;
    redir_acc  = 1'b0;

    case (state_reg)
      RUN: begin
        if (dc_stall) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end else if (ex_branch_taken) begin
          // PC captures the target; if the fetch is still outstanding its
          // return must be discarded later, hence REDIR_WAIT.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          redir_acc  = 1'b1;
          if (ic_stall) state_next = REDIR_WAIT;
        end else if (ic_stall) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (lu) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          lu_resp    = 1'b1;
        end
      end
      REDIR_WAIT: begin
        if (dc_stall) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end else if (ic_stall) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else begin
          // Returned fetch is wrong-path: squash it and refetch the held target.
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      lu_resp    = 1'b0;
      redir_acc  = 1'b0;
    end
  end

  assign redir_pend = (state_reg == REDIR_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] lu_cnt_reg;
  logic [CNT_W-1:0] redir_cnt_reg;
  logic [CNT_W-1:0] dstall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RUN;
      lu_cnt_reg     <= '0;
      redir_cnt_reg  <= '0;
      dstall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (lu_resp)   lu_cnt_reg     <= lu_cnt_reg + CNT_ONE;
      if (redir_acc) redir_cnt_reg  <= redir_cnt_reg + CNT_ONE;
      if (dc_stall)  dstall_cnt_reg <= dstall_cnt_reg + CNT_ONE;
    end
  end

  assign lu_cnt     = lu_cnt_reg;
  assign redir_cnt  = redir_cnt_reg;
  assign dstall_cnt = dstall_cnt_reg;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  assign lu_cnt     = '0;
  assign redir_cnt  = '0;
  assign dstall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table in RUN plus hand-written redirect, D-stall and reset sequences.
// Counter expectations follow HAZARD_PERF_CNT_EN (zero when the macro is undefined).
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_memread, ex_regwrite;
  logic        ex_branch_taken, ic_stall, dc_stall;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, redir_pend;
  logic [31:0] lu_cnt, redir_cnt, dstall_cnt;
  logic [6:0]  outs;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_branch_taken(ex_branch_taken), .ic_stall(ic_stall), .dc_stall(dc_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .redir_pend(redir_pend),
    .lu_cnt(lu_cnt), .redir_cnt(redir_cnt), .dstall_cnt(dstall_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  typedef struct {
    string      name;
    logic       dc, ic, br, mr, rw;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dc, input logic ic, input logic br, input logic mr,
                       input logic rw, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2);
    dc_stall = dc; ic_stall = ic; ex_branch_taken = br;
    ex_memread = mr; ex_regwrite = rw; ex_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  // One cycle: inputs already driven, check at the falling edge, then advance past the rising edge.
  task automatic cyc(input string name, input logic [6:0] exp_outs, input logic exp_pend);
    @(negedge clk);
    $display("[%0t] %s: outs=%b redir_pend=%b", $time, name, outs, redir_pend);
    chk({name, ".outs"}, {25'd0, outs}, {25'd0, exp_outs});
    chk({name, ".pend"}, {31'd0, redir_pend}, {31'd0, exp_pend});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input int lu_e, input int rd_e, input int ds_e);
    chk({name, ".lu_cnt"},     lu_cnt,     PERF ? lu_e : 0);
    chk({name, ".redir_cnt"},  redir_cnt,  PERF ? rd_e : 0);
    chk({name, ".dstall_cnt"}, dstall_cnt, PERF ? ds_e : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name          dc    ic    br    mr    rw    rd     rs1    rs2    u1    u2    exp
    vecs[0]  = '{"idle",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 7'b1111100};
    vecs[1]  = '{"lu_rs1",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 7'b0011101};
    vecs[2]  = '{"x0_src",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 7'b1111100};
    vecs[3]  = '{"rs2_unused",1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  5'd1,  5'd7,  1'b1, 1'b0, 7'b1111100};
    vecs[4]  = '{"lu_rs2",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  5'd1,  5'd7,  1'b0, 1'b1, 7'b0011101};
    vecs[5]  = '{"no_regwr",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 7'b1111100};
    vecs[6]  = '{"not_load",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 7'b1111100};
    vecs[7]  = '{"br_over_lu",1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 7'b1111111};
    vecs[8]  = '{"ic_stall",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 7'b0011101};
    vecs[9]  = '{"ic_and_lu", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  5'd9,  5'd0,  1'b1, 1'b0, 7'b0011101};
    vecs[10] = '{"dc_stall",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 7'b0000000};
    vecs[11] = '{"dc_and_br", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 7'b0000000};
    vecs[12] = '{"dc_and_lu", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  5'd0,  5'd3,  1'b0, 1'b1, 7'b0000000};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3;
    chk("reset.outs", {25'd0, outs}, 32'd0);
    chk("reset.pend", {31'd0, redir_pend}, 32'd0);
    chk_cnt("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table of single-cycle responses in RUN (none of them leaves RUN)
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].dc, vecs[i].ic, vecs[i].br, vecs[i].mr, vecs[i].rw,
            vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2);
      cyc(vecs[i].name, vecs[i].exp, 1'b0);
    end
    // lu response issued by vectors 1 and 4; branch accepted by 7; dc_stall in 10..12
    chk_cnt("table", 2, 1, 3);

    // Branch during a 3-cycle I-cache miss
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("icmiss.br", 7'b1111111, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("icmiss.w1", 7'b0011101, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("icmiss.w2_br_ignored", 7'b0011101, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("icmiss.fall", 7'b0111111, 1'b1);
    cyc("icmiss.run", 7'b1111100, 1'b0);
    chk_cnt("icmiss", 2, 2, 3);

    // D-cache stall over a pending redirect
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("dcwait.br", 7'b1111111, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc($sformatf("dcwait.dc%0d", k), 7'b0000000, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("dcwait.fall", 7'b0111111, 1'b1);
    cyc("dcwait.run", 7'b1111100, 1'b0);
    chk_cnt("dcwait", 2, 3, 7);

    // Reset asserted mid-REDIR_WAIT
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("rstwait.br", 7'b1111111, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    chk("rstwait.pend_before", {31'd0, redir_pend}, 32'd1);
    rst_n = 1'b0;
    #1;
    $display("[%0t] rstwait.assert: outs=%b redir_pend=%b", $time, outs, redir_pend);
    chk("rstwait.outs", {25'd0, outs}, 32'd0);
    chk("rstwait.pend", {31'd0, redir_pend}, 32'd0);
    chk_cnt("rstwait", 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rstwait.run_ic", 7'b0011101, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("rstwait.run_idle", 7'b1111100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
